// File: rtl/histogram_output_writer_if.sv
// Memory-side bus of the histogram drain stage: scratch read/clear port and output write port.
// The drain engine is the master; the memories (or a bench model) sit on the slave modport.
interface histogram_output_writer_if;
  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 128;

  logic [DATA_W-1:0] scratch_memory_rdata1;
  logic [ADDR_W-1:0] scratch_memory_address_pointer1;
  logic              scratch_memory_write_enable1;
  logic [DATA_W-1:0] scratch_memory_wdata1;
  logic [ADDR_W-1:0] output_memory_address_pointer;
  logic              output_memory_write_enable;
  logic [DATA_W-1:0] output_memory_wdata;

  modport master (
    input  scratch_memory_rdata1,
    output scratch_memory_address_pointer1,
    output scratch_memory_write_enable1,
    output scratch_memory_wdata1,
    output output_memory_address_pointer,
    output output_memory_write_enable,
    output output_memory_wdata
  );

  modport slave (
    output scratch_memory_rdata1,
    input  scratch_memory_address_pointer1,
    input  scratch_memory_write_enable1,
    input  scratch_memory_wdata1,
    input  output_memory_address_pointer,
    input  output_memory_write_enable,
    input  output_memory_wdata
  );
endinterface

// File: rtl/histogram_output_writer.sv
// Drains packed histogram bin words from scratch memory into output memory, optionally
// zeroing each scratch word behind it, and keeps a modulo-2^32 total of every bin drained.
module histogram_output_writer #(
  parameter int unsigned NUM_WORDS         = 16,
  parameter logic [15:0] SCRATCH_BASE_ADDR = 16'd0,
  parameter logic [15:0] OUT_BASE_ADDR     = 16'd0,
  parameter bit          CLEAR_AFTER_READ  = 1'b1
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              start,
  histogram_output_writer_if.master         mem,
  output logic                              busy,
  output logic                              done,
  output logic [31:0]                       total_bin_count
);

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 128;
  localparam int unsigned CNT_W  = 32;
  localparam int unsigned LANES  = DATA_W / CNT_W;
  localparam int unsigned IDX_W  = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_CAPTURE,
    S_WRITE,
    S_DONE
  } state_e;

  state_e              state_q;
  logic [IDX_W-1:0]    idx_q;
  logic [IDX_W-1:0]    idx_d;
  logic [ADDR_W-1:0]   scr_addr_q;
  logic [ADDR_W-1:0]   out_addr_q;
  logic                scr_we_q;
  logic                out_we_q;
  logic [DATA_W-1:0]   buf_q;
  logic [CNT_W-1:0]    total_q;
  logic [CNT_W-1:0]    total_d;
  logic                busy_q;
  logic                done_q;
  logic                last_word_c;

  // Running total plus the four lanes of the word being written; every add wraps at 32 bits.
  always_comb begin
    total_d = total_q;
    for (int unsigned l = 0; l < LANES; l++) begin
      total_d = total_d + buf_q[l*CNT_W +: CNT_W];
    end
    idx_d       = idx_q + IDX_W'(1);
    last_word_c = (idx_q == IDX_W'(NUM_WORDS - 1));
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      scr_addr_q <= '0;
      out_addr_q <= '0;
      scr_we_q   <= 1'b0;
      out_we_q   <= 1'b0;
      buf_q      <= '0;
      total_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      scr_we_q <= 1'b0;
      out_we_q <= 1'b0;
      done_q   <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            total_q    <= '0;
            idx_q      <= '0;
            scr_addr_q <= SCRATCH_BASE_ADDR;
            busy_q     <= 1'b1;
            state_q    <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          state_q <= S_CAPTURE;
        end
        // Read data is valid now; the write strobes for this word are set up for WRITE.
        S_CAPTURE: begin
          buf_q      <= mem.scratch_memory_rdata1;
          out_we_q   <= 1'b1;
          out_addr_q <= OUT_BASE_ADDR + ADDR_W'(idx_q);
          scr_we_q   <= CLEAR_AFTER_READ;
          state_q    <= S_WRITE;
        end
        S_WRITE: begin
          total_q <= total_d;
          idx_q   <= idx_d;
          if (last_word_c) begin
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            scr_addr_q <= SCRATCH_BASE_ADDR + ADDR_W'(idx_d);
            state_q    <= S_ISSUE;
          end
        end
        S_DONE: begin
          idx_q   <= '0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign mem.scratch_memory_address_pointer1 = scr_addr_q;
  assign mem.scratch_memory_write_enable1    = scr_we_q;
  assign mem.scratch_memory_wdata1           = '0;
  assign mem.output_memory_address_pointer   = out_addr_q;
  assign mem.output_memory_write_enable      = out_we_q;
  assign mem.output_memory_wdata             = buf_q;
  assign busy                                = busy_q;
  assign done                                = done_q;
  assign total_bin_count                     = total_q;

endmodule

// File: tb/tb_histogram_output_writer.sv
// Bench for histogram_output_writer: one clearing and one non-clearing instance run in lockstep
// against memory models, with expectations taken from a per-word reference of the scratch contents.
module tb_histogram_output_writer;
  localparam int unsigned NW = 16;

  typedef struct {
    logic [15:0]  addr;
    logic [127:0] data;
  } wr_t;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic        busy_s [2];
  logic        done_s [2];
  logic [31:0] total_s[2];

  int checks = 0;
  int errors = 0;

  histogram_output_writer_if mif0 ();
  histogram_output_writer_if mif1 ();

  histogram_output_writer #(.CLEAR_AFTER_READ(1'b1)) dut0 (
    .clock(clock), .reset(reset), .start(start), .mem(mif0),
    .busy(busy_s[0]), .done(done_s[0]), .total_bin_count(total_s[0])
  );

  histogram_output_writer #(.CLEAR_AFTER_READ(1'b0)) dut1 (
    .clock(clock), .reset(reset), .start(start), .mem(mif1),
    .busy(busy_s[1]), .done(done_s[1]), .total_bin_count(total_s[1])
  );

  always #5 clock = ~clock;

  // Memory models and write/done monitors
  logic [127:0] smem  [2][NW];
  logic [127:0] ld_val[2][NW];
  logic [127:0] model [2][NW];
  logic         ld_req;
  wr_t          wq0[$];
  wr_t          wq1[$];
  int unsigned  done_cnt[2] = '{0, 0};
  int unsigned  swe_cnt1 = 0;

  always @(posedge clock) begin
    mif0.scratch_memory_rdata1 <= smem[0][mif0.scratch_memory_address_pointer1[3:0]];
    mif1.scratch_memory_rdata1 <= smem[1][mif1.scratch_memory_address_pointer1[3:0]];
    if (ld_req) begin
      for (int k = 0; k < NW; k++) begin
        smem[0][k] <= ld_val[0][k];
        smem[1][k] <= ld_val[1][k];
      end
    end else begin
      if (mif0.scratch_memory_write_enable1)
        smem[0][mif0.scratch_memory_address_pointer1[3:0]] <= mif0.scratch_memory_wdata1;
      if (mif1.scratch_memory_write_enable1)
        smem[1][mif1.scratch_memory_address_pointer1[3:0]] <= mif1.scratch_memory_wdata1;
    end
    if (mif0.output_memory_write_enable)
      wq0.push_back('{mif0.output_memory_address_pointer, mif0.output_memory_wdata});
    if (mif1.output_memory_write_enable)
      wq1.push_back('{mif1.output_memory_address_pointer, mif1.output_memory_wdata});
    if (done_s[0] === 1'b1) done_cnt[0] <= done_cnt[0] + 1;
    if (done_s[1] === 1'b1) done_cnt[1] <= done_cnt[1] + 1;
    if (mif1.scratch_memory_write_enable1 === 1'b1) swe_cnt1 <= swe_cnt1 + 1;
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] bins_in_word(input logic [127:0] w);
    logic [31:0] s;
    s = 32'd0;
    for (int l = 0; l < 4; l++) s = s + w[l*32 +: 32];
    return s;
  endfunction

  task automatic check_idle_zero(input string tag);
    check({tag, "_busy0"}, 128'(busy_s[0]), 128'(0));
    check({tag, "_busy1"}, 128'(busy_s[1]), 128'(0));
    check({tag, "_done0"}, 128'(done_s[0]), 128'(0));
    check({tag, "_total0"}, 128'(total_s[0]), 128'(0));
    check({tag, "_total1"}, 128'(total_s[1]), 128'(0));
    check({tag, "_saddr0"}, 128'(mif0.scratch_memory_address_pointer1), 128'(0));
    check({tag, "_oaddr0"}, 128'(mif0.output_memory_address_pointer), 128'(0));
    check({tag, "_swe0"}, 128'(mif0.scratch_memory_write_enable1), 128'(0));
    check({tag, "_owe0"}, 128'(mif0.output_memory_write_enable), 128'(0));
    check({tag, "_owe1"}, 128'(mif1.output_memory_write_enable), 128'(0));
    check({tag, "_owdata0"}, mif0.output_memory_wdata, 128'(0));
    check({tag, "_swdata0"}, mif0.scratch_memory_wdata1, 128'(0));
  endtask

  // mode 0: counting pattern, 1: random, 2: all ones
  task automatic load(input int mode);
    logic [127:0] v;
    for (int k = 0; k < NW; k++) begin
      case (mode)
        0:       v = {32'(4*k+1), 32'(4*k+2), 32'(4*k+3), 32'(4*k+4)};
        1:       v = {$urandom, $urandom, $urandom, $urandom};
        default: v = '1;
      endcase
      for (int d = 0; d < 2; d++) begin
        ld_val[d][k] = v;
        model[d][k]  = v;
      end
    end
    @(negedge clock) ld_req = 1'b1;
    @(negedge clock) ld_req = 1'b0;
  endtask

  task automatic run_drain(input string tag, input bit spam, input int reset_at, input bit now);
    int          n;
    int          gap;
    int          wb[2];
    int unsigned db[2];
    logic [31:0] exp_tot[2];
    wr_t         w;
    wb[0] = wq0.size();
    wb[1] = wq1.size();
    db    = done_cnt;
    for (int d = 0; d < 2; d++) begin
      exp_tot[d] = 32'd0;
      for (int k = 0; k < NW; k++) exp_tot[d] = exp_tot[d] + bins_in_word(model[d][k]);
    end
    if (!now) @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    n   = 1;
    gap = 0;
    if (!spam) start = 1'b0;
    while (done_s[0] !== 1'b1 && n < 200 && n != reset_at) begin
      if (busy_s[0] !== 1'b1 || busy_s[1] !== 1'b1) gap++;
      @(negedge clock);
      n++;
    end
    if (reset_at != 0 && n == reset_at) begin
      // Reset lands in the WRITE cycle of word reset_at/3 - 1; that word still gets written.
      reset = 1'b1;
      start = 1'b0;
      @(negedge clock);
      check_idle_zero({tag, "_after_reset"});
      reset = 1'b0;
      check({tag, "_busy_gap"}, 128'(gap), 128'(0));
      check({tag, "_nwrites0"}, 128'(wq0.size() - wb[0]), 128'(reset_at / 3));
      check({tag, "_done_cnt"}, 128'(done_cnt[0] - db[0]), 128'(0));
      for (int k = 0; k < reset_at / 3; k++) model[0][k] = '0;
      for (int k = 0; k < NW; k++) check($sformatf("%s_scr0_%0d", tag, k), smem[0][k], model[0][k]);
      return;
    end
    check({tag, "_latency"}, 128'(n), 128'(49));
    check({tag, "_done1"}, 128'(done_s[1]), 128'(1));
    check({tag, "_busy_gap"}, 128'(gap), 128'(0));
    check({tag, "_busy_in_done"}, 128'(busy_s[0]), 128'(1));
    @(negedge clock);
    start = 1'b0;
    for (int d = 0; d < 2; d++) begin
      check($sformatf("%s_idle_busy%0d", tag, d), 128'(busy_s[d]), 128'(0));
      check($sformatf("%s_idle_done%0d", tag, d), 128'(done_s[d]), 128'(0));
      check($sformatf("%s_total%0d", tag, d), 128'(total_s[d]), 128'(exp_tot[d]));
      check($sformatf("%s_done_cnt%0d", tag, d), 128'(done_cnt[d] - db[d]), 128'(1));
    end
    check({tag, "_nwrites0"}, 128'(wq0.size() - wb[0]), 128'(NW));
    check({tag, "_nwrites1"}, 128'(wq1.size() - wb[1]), 128'(NW));
    for (int k = 0; k < NW; k++) begin
      if (wb[0] + k < wq0.size()) begin
        w = wq0[wb[0] + k];
        check($sformatf("%s_waddr0_%0d", tag, k), 128'(w.addr), 128'(k));
        check($sformatf("%s_wdata0_%0d", tag, k), w.data, model[0][k]);
      end
      if (wb[1] + k < wq1.size()) begin
        w = wq1[wb[1] + k];
        check($sformatf("%s_wdata1_%0d", tag, k), w.data, model[1][k]);
      end
    end
    for (int k = 0; k < NW; k++) begin
      model[0][k] = '0;
      check($sformatf("%s_scr0_%0d", tag, k), smem[0][k], model[0][k]);
      check($sformatf("%s_scr1_%0d", tag, k), smem[1][k], model[1][k]);
    end
    check({tag, "_swe1_never"}, 128'(swe_cnt1), 128'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    reset  = 1'b1;
    start  = 1'b0;
    ld_req = 1'b0;
    repeat (3) @(negedge clock);
    check_idle_zero("reset");
    reset = 1'b0;

    load(0);
    run_drain("count", 1'b0, 0, 1'b0);
    check("count_total_2080", 128'(total_s[0]), 128'(2080));

    load(1);
    run_drain("spam", 1'b1, 0, 1'b0);

    load(1);
    run_drain("midreset", 1'b0, 18, 1'b0);
    run_drain("restart", 1'b0, 0, 1'b0);

    load(2);
    run_drain("ones", 1'b0, 0, 1'b0);
    check("ones_wrap0", 128'(total_s[0]), 128'(32'hFFFF_FFC0));
    check("ones_wrap1", 128'(total_s[1]), 128'(32'hFFFF_FFC0));

    load(1);
    run_drain("b2b_first", 1'b0, 0, 1'b0);
    run_drain("b2b_second", 1'b0, 0, 1'b1);

    repeat (4) @(negedge clock);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
